// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD zero-latency read ports, two write ports
// (port 1 wins on collision), optional write-to-read bypass and a busy scoreboard.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_idx,
  output logic                wr_conflict
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_conflict_q, wr_conflict_d;
  logic            w0_ok, w1_ok;

  assign w0_ok = we0 && (wa0 != '0);
  assign w1_ok = we1 && (wa1 != '0);

  // Port 1 is applied last so it wins a collision; a new issue overrides a retiring write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w0_ok) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (w1_ok) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (iss_en) begin
      busy_d[iss_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
    wr_conflict_d = w0_ok && w1_ok && (wa0 == wa1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] idx;
    logic          hit0, hit1, reiss;

    assign idx   = ra[k*AW +: AW];
    assign hit0  = (BYPASS != 0) && we0 && (wa0 == idx);
    assign hit1  = (BYPASS != 0) && we1 && (wa1 == idx);
    assign reiss = iss_en && (iss_idx == idx);

    // Bypass is suppressed while reset is low so reads show zeros immediately.
    assign rd[k*XLEN +: XLEN] = (!reset || idx == '0) ? '0 :
                                hit1 ? wd1 :
                                hit0 ? wd0 : regs_q[idx];
    assign rbusy[k] = reset && busy_q[idx] && !((hit0 || hit1) && !reiss);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypassing 4-read-port instance and one
// non-bypassing 2-read-port instance share write/issue traffic against a bench model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, iss_en;
  logic [4:0]  wa0, wa1, iss_idx;
  logic [31:0] wd0, wd1;
  logic [19:0] ra_a;
  logic [9:0]  ra_b;
  logic [127:0] rd_a;
  logic [63:0] rd_b;
  logic [3:0]  rbusy_a;
  logic [1:0]  rbusy_b;
  logic        wr_conflict_a, wr_conflict_b;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  logic [31:0] mregs [32];
  logic [31:0] mbusy;
  logic        mconf;

  string       tag_q [$];
  int          src_q [$];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(4), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
    .iss_en(iss_en), .iss_idx(iss_idx), .wr_conflict(wr_conflict_a)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
    .iss_en(iss_en), .iss_idx(iss_idx), .wr_conflict(wr_conflict_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int src);
    if (src < 4)   return rd_a[src*32 +: 32];
    if (src < 6)   return rd_b[(src-4)*32 +: 32];
    if (src < 10)  return {31'd0, rbusy_a[src-6]};
    if (src < 12)  return {31'd0, rbusy_b[src-10]};
    if (src == 12) return {31'd0, wr_conflict_a};
    return {31'd0, wr_conflict_b};
  endfunction

  function automatic logic [31:0] expRd(input logic [4:0] idx, input bit byp);
    if (!reset || idx == 5'd0) return 32'd0;
    if (byp && we1 && wa1 == idx) return wd1;
    if (byp && we0 && wa0 == idx) return wd0;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] expBusy(input logic [4:0] idx, input bit byp);
    logic b;
    if (!reset) return 32'd0;
    b = mbusy[idx];
    if (byp && ((we0 && wa0 == idx) || (we1 && wa1 == idx)) && !(iss_en && iss_idx == idx))
      b = 1'b0;
    return {31'd0, b};
  endfunction

  task automatic pushExp(input string tag, input int src, input logic [31:0] exp);
    tag_q.push_back(tag);
    src_q.push_back(src);
    exp_q.push_back(exp);
  endtask

  task automatic pushExpect();
    logic [4:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = ra_a[k*5 +: 5];
      pushExp($sformatf("%s rdA%0d[r%0d]", phase, k, idx), k, expRd(idx, 1'b1));
      pushExp($sformatf("%s rbusyA%0d[r%0d]", phase, k, idx), 6 + k, expBusy(idx, 1'b1));
    end
    for (int k = 0; k < 2; k++) begin
      idx = ra_b[k*5 +: 5];
      pushExp($sformatf("%s rdB%0d[r%0d]", phase, k, idx), 4 + k, expRd(idx, 1'b0));
      pushExp($sformatf("%s rbusyB%0d[r%0d]", phase, k, idx), 10 + k, expBusy(idx, 1'b0));
    end
    pushExp($sformatf("%s conflictA", phase), 12, {31'd0, mconf && reset});
    pushExp($sformatf("%s conflictB", phase), 13, {31'd0, mconf && reset});
  endtask

  task automatic drainQueue();
    while (exp_q.size() > 0) begin
      checkOutput(tag_q.pop_front(), observe(src_q.pop_front()), exp_q.pop_front());
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mbusy = 32'd0;
    mconf = 1'b0;
  endtask

  task automatic updateModel();
    logic nconf;
    if (reset) begin
      nconf = we0 && we1 && (wa0 == wa1) && (wa0 != 5'd0);
      if (we0 && wa0 != 5'd0) begin mregs[wa0] = wd0; mbusy[wa0] = 1'b0; end
      if (we1 && wa1 != 5'd0) begin mregs[wa1] = wd1; mbusy[wa1] = 1'b0; end
      if (iss_en && iss_idx != 5'd0) mbusy[iss_idx] = 1'b1;
      mconf = nconf;
    end
  endtask

  task automatic applyStimulus(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic ie, input logic [4:0] ii);
    we0 = w0; wa0 = a0; wd0 = d0;
    we1 = w1; wa1 = a1; wd1 = d1;
    iss_en = ie; iss_idx = ii;
  endtask

  task automatic setReads(input logic [4:0] r0, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] r3);
    ra_a = {r3, r2, r1, r0};
    ra_b = {r1, r0};
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic checkNow();
    #1;
    pushExpect();
    drainQueue();
  endtask

  task automatic tick();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic stepCycle();
    checkNow();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    clearModel();
    idle();
    setReads(5'd0, 5'd1, 5'd2, 5'd3);
    phase = "reset";
    stepCycle();
    reset = 1'b1;

    phase = "x0";
    applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    setReads(5'd0, 5'd0, 5'd0, 5'd0);
    stepCycle();
    idle();
    stepCycle();

    phase = "collide";
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0);
    setReads(5'd5, 5'd5, 5'd4, 5'd5);
    stepCycle();
    idle();
    stepCycle();
    stepCycle();

    phase = "bypass";
    applyStimulus(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    stepCycle();
    applyStimulus(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    setReads(5'd5, 5'd7, 5'd7, 5'd0);
    stepCycle();
    idle();
    stepCycle();

    phase = "busy";
    setReads(5'd3, 5'd3, 5'd3, 5'd4);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    stepCycle();
    idle();
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h333, 1'b0, 5'd0);
    stepCycle();
    idle();
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    stepCycle();
    applyStimulus(1'b1, 5'd3, 32'h444, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    stepCycle();
    idle();
    stepCycle();

    phase = "sweep";
    for (int i = 1; i < 32; i += 2) begin
      applyStimulus(1'b1, 5'(i), 32'hA500_0000 | (i * 32'h0001_0203),
                    (i + 1) < 32, 5'(i + 1), 32'hA500_0000 | ((i + 1) * 32'h0001_0203),
                    1'b0, 5'd0);
      setReads(5'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3));
      stepCycle();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      setReads(5'(i), 5'(i + 8), 5'(i + 16), 5'(i + 24));
      stepCycle();
    end

    phase = "random";
    for (int n = 0; n < 150; n++) begin
      applyStimulus(1'($urandom_range(1)), 5'($urandom_range(31)), $urandom,
                    1'($urandom_range(1)), 5'($urandom_range(31)), $urandom,
                    $urandom_range(3) == 0, 5'($urandom_range(31)));
      if (n % 8 == 0) wa1 = wa0;
      setReads(5'($urandom_range(31)), 5'($urandom_range(31)),
               5'($urandom_range(31)), 5'($urandom_range(31)));
      stepCycle();
    end

    phase = "midreset";
    applyStimulus(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 32'h66, 1'b1, 5'd10);
    setReads(5'd9, 5'd10, 5'd5, 5'd7);
    stepCycle();
    applyStimulus(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    checkNow();
    reset = 1'b0;
    clearModel();
    checkNow();
    tick();
    checkNow();
    reset = 1'b1;
    idle();
    phase = "postreset";
    stepCycle();
    setReads(5'd3, 5'd31, 5'd1, 5'd2);
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
